// File: rtl/pixel_bridge_if.sv
// Pixel FIFO read/write port bundle between the ADC-side source FIFO and the DAC-side sink FIFO.
// master = bridge (pops source, pushes sink); slave = the FIFOs / environment.
interface pixel_bridge_if;
    logic        src_empty;
    logic        src_rd_en;
    logic [37:0] src_rd_data;
    logic        dst_full;
    logic        dst_wr_en;
    logic [37:0] dst_wr_data;

    modport master (
        input  src_empty, src_rd_data, dst_full,
        output src_rd_en, dst_wr_en, dst_wr_data
    );

    modport slave (
        output src_empty, src_rd_data, dst_full,
        input  src_rd_en, dst_wr_en, dst_wr_data
    );
endinterface

// File: rtl/pixel_bridge.sv
// Pixel stage: frame lock + raster continuity check + test pattern, source FIFO -> 2-entry buffer -> sink FIFO.
// Latency 2 cycles read-to-write; sink full stalls reads within the cycle, never drops a word.
module pixel_bridge #(
    parameter int          H_ACTIVE  = 800,
    parameter int          V_ACTIVE  = 600,
    parameter logic [15:0] SOLID_RGB = 16'hF81F
) (
    input  logic        clk,
    input  logic        rst_n,
    pixel_bridge_if.master pix,
    input  logic [1:0]  mode,
    output logic        locked,
    output logic [15:0] frame_count,
    output logic [15:0] sync_err_count
);
    localparam logic [0:0]  SEARCH = 1'b0;
    localparam logic [0:0]  RUN    = 1'b1;
    localparam logic [10:0] X_LAST = 11'(H_ACTIVE - 1);
    localparam logic [10:0] Y_LAST = 11'(V_ACTIVE - 1);

    logic [0:0]  state, state_nxt;
    logic [10:0] exp_x, exp_y, nxt_x, nxt_y;
    logic [1:0]  mode_q, eff_mode;
    logic        run_en;
    logic        in_flight;
    logic [1:0]  occ, occ_after;
    logic [37:0] buf0, buf1;

    logic [10:0] in_x, in_y;
    logic [15:0] in_rgb, out_rgb;
    logic [2:0]  bar;
    logic        is_origin, is_exp;
    logic        accept, frame_start, sync_err;
    logic        push, pop;
    logic [37:0] acc_word;

    assign in_x   = pix.src_rd_data[37:27];
    assign in_y   = pix.src_rd_data[26:16];
    assign in_rgb = pix.src_rd_data[15:0];

    assign is_origin = (in_x == 11'd0) && (in_y == 11'd0);
    assign is_exp    = (in_x == exp_x) && (in_y == exp_y);

    always_comb begin
        accept      = 1'b0;
        frame_start = 1'b0;
        sync_err    = 1'b0;
        state_nxt   = state;
        if (in_flight) begin
            if (state == SEARCH) begin
                if (is_origin) begin
                    accept      = 1'b1;
                    frame_start = 1'b1;
                    state_nxt   = RUN;
                end
            end else if (is_exp) begin
                accept      = 1'b1;
                frame_start = is_origin;
            end else begin
                // A misplaced origin is still a usable frame start; anything else loses lock.
                sync_err = 1'b1;
                if (is_origin) begin
                    accept      = 1'b1;
                    frame_start = 1'b1;
                end else begin
                    state_nxt = SEARCH;
                end
            end
        end
    end

    // The frame-start word already belongs to the new frame, so it uses the newly sampled mode.
    assign eff_mode = frame_start ? mode : mode_q;
    assign bar      = in_x[9:7];

    always_comb begin
        case (eff_mode)
            2'd1:    out_rgb = {{5{bar[2]}}, {6{bar[1]}}, {5{bar[0]}}};
            2'd2:    out_rgb = SOLID_RGB;
            default: out_rgb = in_rgb;
        endcase
    end

    assign acc_word = {in_x, in_y, out_rgb};

    always_comb begin
        nxt_x = in_x + 11'd1;
        nxt_y = in_y;
        if (in_x == X_LAST) begin
            nxt_x = 11'd0;
            nxt_y = (in_y == Y_LAST) ? 11'd0 : in_y + 11'd1;
        end
    end

    assign push = accept;
    assign pop  = (occ != 2'd0) && !pix.dst_full;

    // Occupancy is taken net of this cycle's pop so a free-flowing pipe keeps one read per cycle.
    assign occ_after       = occ - {1'b0, pop};
    assign pix.src_rd_en   = run_en && !pix.src_empty && ((occ_after + {1'b0, in_flight}) < 2'd2);
    assign pix.dst_wr_en   = pop;
    assign pix.dst_wr_data = buf0;
    assign locked          = (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_en         <= 1'b0;
            in_flight      <= 1'b0;
            state          <= SEARCH;
            exp_x          <= 11'd0;
            exp_y          <= 11'd0;
            mode_q         <= 2'd0;
            frame_count    <= 16'd0;
            sync_err_count <= 16'd0;
            occ            <= 2'd0;
            buf0           <= 38'd0;
            buf1           <= 38'd0;
        end else begin
            // Holds reads off for the first cycle out of reset.
            run_en    <= 1'b1;
            in_flight <= pix.src_rd_en;
            state     <= state_nxt;
            if (accept) begin
                exp_x <= nxt_x;
                exp_y <= nxt_y;
            end
            if (frame_start) begin
                mode_q      <= mode;
                frame_count <= frame_count + 16'd1;
            end
            if (sync_err && (sync_err_count != 16'hFFFF))
                sync_err_count <= sync_err_count + 16'd1;

            occ <= occ + {1'b0, push} - {1'b0, pop};
            case ({push, pop})
                2'b01: buf0 <= buf1;
                2'b10: begin
                    if (occ == 2'd0) buf0 <= acc_word;
                    else             buf1 <= acc_word;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        buf0 <= acc_word;
                    end else begin
                        buf0 <= buf1;
                        buf1 <= acc_word;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pixel_bridge.sv
// Self-checking bench for pixel_bridge: source FIFO model, scoreboard on the sink side, vector table plus corner sequences.
module tb_pixel_bridge;
    localparam int H = 800;
    localparam int V = 2;
    localparam int FRAME = H * V;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        locked;
    logic [15:0] frame_count, sync_err_count;

    pixel_bridge_if pif();

    pixel_bridge #(.H_ACTIVE(H), .V_ACTIVE(V), .SOLID_RGB(16'hF81F)) dut (
        .clk(clk), .rst_n(rst_n), .pix(pif), .mode(mode),
        .locked(locked), .frame_count(frame_count), .sync_err_count(sync_err_count)
    );

    always #3 clk = ~clk;

    // Source FIFO model: data appears the cycle after the read strobe.
    logic [37:0] src_mem [0:16383];
    int          src_len = 0;
    int          rd_idx = 0;
    assign pif.src_empty = (rd_idx >= src_len);

    always @(posedge clk) begin
        if (pif.src_rd_en && !pif.src_empty) begin
            pif.src_rd_data <= src_mem[rd_idx];
            rd_idx          <= rd_idx + 1;
        end
    end

    logic [37:0] exp_q [$];
    logic [15:0] cap_rgb [0:H-1];
    int checks = 0, failures = 0;
    int cyc = 0, rd_cnt = 0, wr_cnt = 0, last_rd_cyc = 0, last_wr_cyc = 0;

    initial begin
        logic [37:0] e;
        forever begin
            @(negedge clk);
            cyc = cyc + 1;
            if (rst_n) begin
                if (pif.src_rd_en) begin
                    rd_cnt = rd_cnt + 1;
                    last_rd_cyc = cyc;
                end
                if (pif.dst_full) begin
                    checks = checks + 1;
                    if (pif.dst_wr_en) begin
                        failures = failures + 1;
                        $display("FAIL wr_while_full: dst_wr_en=1 required=0 at cycle %0d", cyc);
                    end
                end
                if (pif.dst_wr_en) begin
                    wr_cnt = wr_cnt + 1;
                    last_wr_cyc = cyc;
                    checks = checks + 1;
                    if (exp_q.size() == 0) begin
                        failures = failures + 1;
                        $display("FAIL unexpected_write: got %h required none", pif.dst_wr_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (pif.dst_wr_data !== e) begin
                            failures = failures + 1;
                            $display("FAIL write_data: got %h required %h", pif.dst_wr_data, e);
                        end
                    end
                    if (pif.dst_wr_data[26:16] == 11'd0 && pif.dst_wr_data[37:27] < 11'(H))
                        cap_rgb[pif.dst_wr_data[37:27]] = pif.dst_wr_data[15:0];
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks = checks + 1;
        if (act !== req) begin
            failures = failures + 1;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] model_rgb(input logic [1:0] m, input logic [10:0] x, input logic [15:0] rgb);
        logic [2:0] b;
        b = x[9:7];
        case (m)
            2'd1:    return {{5{b[2]}}, {6{b[1]}}, {5{b[0]}}};
            2'd2:    return 16'hF81F;
            default: return rgb;
        endcase
    endfunction

    task automatic push_word(input logic [10:0] x, input logic [10:0] y, input logic [15:0] rgb,
                             input bit exp_wr, input logic [15:0] exp_rgb);
        src_mem[src_len] = {x, y, rgb};
        src_len = src_len + 1;
        if (exp_wr) exp_q.push_back({x, y, exp_rgb});
    endtask

    task automatic push_range(input logic [1:0] m, input int from, input int to, input bit exp_wr);
        logic [10:0] x, y;
        logic [15:0] rgb;
        for (int i = from; i < to; i++) begin
            x   = 11'(i % H);
            y   = 11'(i / H);
            rgb = 16'($urandom);
            push_word(x, y, rgb, exp_wr, model_rgb(m, x, rgb));
        end
    endtask

    task automatic drain(input bit bp, input int budget, input string name);
        int settle = 0;
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge clk); #1;
            if (rd_idx >= src_len && exp_q.size() == 0) begin
                pif.dst_full = 1'b0;
                settle = settle + 1;
                if (settle >= 4) done = 1'b1;
            end else begin
                settle = 0;
                pif.dst_full = bp ? ($urandom_range(0, 3) == 0) : 1'b0;
            end
        end
        checks = checks + 1;
        if (!done) begin
            failures = failures + 1;
            $display("FAIL drain_%s: pending=%0d unread=%0d required 0/0", name, exp_q.size(), src_len - rd_idx);
        end
    endtask

    typedef struct {
        logic [10:0] x;
        logic [10:0] y;
        bit          wr;
        bit          lk;
        logic [15:0] fc;
        logic [15:0] ec;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int wr0, t0, r0, rs, ws, base;
        logic [15:0] rgb;

        tbl[0]  = '{11'd5,   11'd3, 1'b0, 1'b0, 16'd0, 16'd0};
        tbl[1]  = '{11'd6,   11'd3, 1'b0, 1'b0, 16'd0, 16'd0};
        tbl[2]  = '{11'd0,   11'd0, 1'b1, 1'b1, 16'd1, 16'd0};
        tbl[3]  = '{11'd1,   11'd0, 1'b1, 1'b1, 16'd1, 16'd0};
        tbl[4]  = '{11'd2,   11'd0, 1'b1, 1'b1, 16'd1, 16'd0};
        tbl[5]  = '{11'd4,   11'd0, 1'b0, 1'b0, 16'd1, 16'd1};
        tbl[6]  = '{11'd5,   11'd0, 1'b0, 1'b0, 16'd1, 16'd1};
        tbl[7]  = '{11'd0,   11'd0, 1'b1, 1'b1, 16'd2, 16'd1};
        tbl[8]  = '{11'd1,   11'd0, 1'b1, 1'b1, 16'd2, 16'd1};
        tbl[9]  = '{11'd0,   11'd0, 1'b1, 1'b1, 16'd3, 16'd2};
        tbl[10] = '{11'd1,   11'd0, 1'b1, 1'b1, 16'd3, 16'd2};
        tbl[11] = '{11'd900, 11'd0, 1'b0, 1'b0, 16'd3, 16'd3};

        pif.dst_full = 1'b0;
        push_word(11'd7, 11'd7, 16'h1234, 1'b0, 16'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_src_rd_en", pif.src_rd_en, 1'b0);
        chk("rst_dst_wr_en", pif.dst_wr_en, 1'b0);
        chk("rst_dst_wr_data", pif.dst_wr_data, 38'd0);
        chk("rst_locked", locked, 1'b0);
        chk("rst_frame_count", frame_count, 16'd0);
        chk("rst_sync_err_count", sync_err_count, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drain(1'b0, 50, "dummy");

        for (int i = 0; i < 12; i++) begin
            wr0 = wr_cnt;
            rgb = 16'($urandom);
            push_word(tbl[i].x, tbl[i].y, rgb, tbl[i].wr, rgb);
            drain(1'b0, 50, "vec");
            if (tbl[i].wr) chk("vec_latency", 64'(last_wr_cyc - last_rd_cyc), 64'd2);
            else           chk("vec_no_write", 64'(wr_cnt - wr0), 64'd0);
            chk("vec_locked", locked, tbl[i].lk);
            chk("vec_frame_count", frame_count, tbl[i].fc);
            chk("vec_sync_err_count", sync_err_count, tbl[i].ec);
        end

        // Full frame with a 50-cycle sink stall mid-line.
        base = src_len;
        rs = rd_cnt;
        ws = wr_cnt;
        t0 = cyc;
        push_range(2'd0, 0, FRAME, 1'b1);
        for (int i = 0; i < 2000 && rd_idx < base + 400; i++) begin
            @(posedge clk); #1;
        end
        pif.dst_full = 1'b1;
        r0 = rd_cnt;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (i == 2) r0 = rd_cnt;
        end
        chk("reads_while_full", 64'(rd_cnt - r0), 64'd0);
        chk("outstanding_at_stall", 64'((rd_cnt - rs) - (wr_cnt - ws)), 64'd2);
        pif.dst_full = 1'b0;
        drain(1'b0, 4000, "stall_frame");
        chk("frame_writes", 64'(wr_cnt - ws), 64'(FRAME));
        chk("throughput", 64'(cyc - t0 <= FRAME + 50 + 20), 64'd1);
        chk("stall_frame_count", frame_count, 16'd4);
        chk("stall_sync_err_count", sync_err_count, 16'd3);
        chk("stall_locked", locked, 1'b1);

        // Mode changes mid-frame only take effect at the next frame start.
        push_range(2'd0, 0, FRAME / 2, 1'b1);
        drain(1'b1, 6000, "mode_a1");
        mode = 2'd1;
        push_range(2'd0, FRAME / 2, FRAME, 1'b1);
        push_range(2'd1, 0, FRAME, 1'b1);
        drain(1'b1, 12000, "mode_b");
        chk("bar_x0", cap_rgb[0], 16'h0000);
        chk("bar_x127", cap_rgb[127], 16'h0000);
        chk("bar_x128", cap_rgb[128], 16'h001F);
        chk("bar_x512", cap_rgb[512], 16'hF800);
        chk("bar_x799", cap_rgb[799], 16'hFFE0);
        push_range(2'd1, 0, FRAME / 2, 1'b1);
        drain(1'b1, 6000, "mode_c1");
        mode = 2'd2;
        push_range(2'd1, FRAME / 2, FRAME, 1'b1);
        push_range(2'd2, 0, FRAME, 1'b1);
        drain(1'b1, 12000, "mode_d");
        chk("solid_x5", cap_rgb[5], 16'hF81F);
        chk("solid_x600", cap_rgb[600], 16'hF81F);
        chk("mode_frame_count", frame_count, 16'd8);
        chk("mode_sync_err_count", sync_err_count, 16'd3);

        // Reset mid-frame with the buffer full.
        @(posedge clk); #1;
        pif.dst_full = 1'b1;
        push_range(2'd2, 0, FRAME, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        chk("prereset_head", pif.dst_wr_data, {11'd0, 11'd0, 16'hF81F});
        rst_n = 1'b0;
        #1;
        chk("midrst_src_rd_en", pif.src_rd_en, 1'b0);
        chk("midrst_dst_wr_data", pif.dst_wr_data, 38'd0);
        chk("midrst_locked", locked, 1'b0);
        chk("midrst_frame_count", frame_count, 16'd0);
        chk("midrst_sync_err_count", sync_err_count, 16'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pif.dst_full = 1'b0;
        mode = 2'd0;
        push_range(2'd0, 0, FRAME, 1'b1);
        drain(1'b1, 12000, "after_reset");
        chk("after_reset_frame_count", frame_count, 16'd1);
        chk("after_reset_sync_err_count", sync_err_count, 16'd0);
        chk("after_reset_locked", locked, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
